// File: rtl/fsm_pin_mapper.sv
// fsm_pin_mapper: per-FSM sticky pin output / pin drive register file.
// OUT, SET and side-set writes are mapped onto the pins through a base/count
// window that wraps from pin 31 back to pin 0. The outputs come straight from
// flops and feed the output arbitrator's fsm_output/fsm_drive slot.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              FSM enabled; all write strobes are ignored when low
//   restart             synchronous clear of pin state and collision flag
//   out_*/set_*         OUT / SET mapping (base, count) and write (valid, dest, data)
//   sideset_*           side-set mapping, target select and write
//   pin_output          registered pin output values
//   pin_drive           registered pin drive enables
//   collision           sticky flag: OUT and SET strobed in the same cycle
//
// Build option: SIDESET_OPT_EN treats the top side-set bit as an enable bit.
module fsm_pin_mapper #(
  parameter int unsigned NUM_PINS = 32,
  parameter int unsigned SET_MAX  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                restart,
  input  logic [4:0]          out_base,
  input  logic [5:0]          out_count,
  input  logic [4:0]          set_base,
  input  logic [2:0]          set_count,
  input  logic [4:0]          sideset_base,
  input  logic [2:0]          sideset_count,
  input  logic                sideset_pindir,
  input  logic                out_valid,
  input  logic                out_dest,
  input  logic [NUM_PINS-1:0] out_data,
  input  logic                set_valid,
  input  logic                set_dest,
  input  logic [SET_MAX-1:0]  set_data,
  input  logic                sideset_valid,
  input  logic [SET_MAX-1:0]  sideset_data,
  output logic [NUM_PINS-1:0] pin_output,
  output logic [NUM_PINS-1:0] pin_drive,
  output logic                collision
);

  localparam int unsigned DBL_W = 2 * NUM_PINS;

  logic [NUM_PINS-1:0] pin_output_q, pin_output_d;
  logic [NUM_PINS-1:0] pin_drive_q, pin_drive_d;
  logic                collision_q, collision_d;

  // Rotate left by base, modulo the pin count.
  function automatic logic [NUM_PINS-1:0] rotl(input logic [NUM_PINS-1:0] x,
                                               input logic [4:0] base);
    logic [DBL_W-1:0] dbl;
    dbl = {x, x} << base;
    return dbl[DBL_W-1 -: NUM_PINS];
  endfunction

  // cnt consecutive ones starting at pin base, wrapping past the top pin.
  function automatic logic [NUM_PINS-1:0] span_mask(input logic [4:0] base,
                                                    input logic [5:0] cnt);
    logic [NUM_PINS-1:0] low;
    low = (cnt >= 6'(NUM_PINS)) ? '1 : ((NUM_PINS'(1) << cnt) - NUM_PINS'(1));
    return rotl(low, base);
  endfunction

  // Masked read-modify-write of one register through a base/count window.
  function automatic logic [NUM_PINS-1:0] apply(input logic [NUM_PINS-1:0] cur,
                                                input logic [NUM_PINS-1:0] data,
                                                input logic [4:0] base,
                                                input logic [5:0] cnt);
    logic [NUM_PINS-1:0] mask;
    mask = span_mask(base, cnt);
    return (cur & ~mask) | (rotl(data, base) & mask);
  endfunction

  logic [5:0] out_cnt_c;
  logic [2:0] set_cnt_c;
  logic [2:0] ss_cnt_c;
  logic [2:0] ss_eff_cnt_c;
  logic       ss_go_c;
  logic       do_out_c;
  logic       do_set_c;

  // Count clamping and strobe qualification.
  always_comb begin
    out_cnt_c = (out_count > 6'(NUM_PINS)) ? 6'(NUM_PINS) : out_count;
    set_cnt_c = (set_count > 3'(SET_MAX)) ? 3'(SET_MAX) : set_count;
    ss_cnt_c  = (sideset_count > 3'(SET_MAX)) ? 3'(SET_MAX) : sideset_count;
    do_out_c  = enable & out_valid;
    do_set_c  = enable & set_valid & ~out_valid;
`ifdef SIDESET_OPT_EN
    // Top side-set bit gates the write; only the bits below it reach the pins.
    ss_eff_cnt_c = (ss_cnt_c >= 3'd2) ? (ss_cnt_c - 3'd1) : 3'd0;
    ss_go_c      = enable & sideset_valid & (ss_cnt_c >= 3'd2) &
                   sideset_data[ss_cnt_c - 3'd1];
`else
    ss_eff_cnt_c = ss_cnt_c;
    ss_go_c      = enable & sideset_valid;
`endif
  end

  // Next state: OUT/SET first, side-set on top, restart overrides everything.
  always_comb begin
    pin_output_d = pin_output_q;
    pin_drive_d  = pin_drive_q;
    collision_d  = collision_q | (enable & out_valid & set_valid);

    if (do_out_c) begin
      if (out_dest) pin_drive_d  = apply(pin_drive_d,  out_data, out_base, out_cnt_c);
      else          pin_output_d = apply(pin_output_d, out_data, out_base, out_cnt_c);
    end else if (do_set_c) begin
      if (set_dest) pin_drive_d  = apply(pin_drive_d,  NUM_PINS'(set_data), set_base,
                                         6'(set_cnt_c));
      else          pin_output_d = apply(pin_output_d, NUM_PINS'(set_data), set_base,
                                         6'(set_cnt_c));
    end

    if (ss_go_c) begin
      if (sideset_pindir) pin_drive_d  = apply(pin_drive_d, NUM_PINS'(sideset_data),
                                               sideset_base, 6'(ss_eff_cnt_c));
      else                pin_output_d = apply(pin_output_d, NUM_PINS'(sideset_data),
                                               sideset_base, 6'(ss_eff_cnt_c));
    end

    if (restart) begin
      pin_output_d = '0;
      pin_drive_d  = '0;
      collision_d  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_output_q <= '0;
      pin_drive_q  <= '0;
      collision_q  <= 1'b0;
    end else begin
      pin_output_q <= pin_output_d;
      pin_drive_q  <= pin_drive_d;
      collision_q  <= collision_d;
    end
  end

  assign pin_output = pin_output_q;
  assign pin_drive  = pin_drive_q;
  assign collision  = collision_q;

endmodule

// File: tb/tb_fsm_pin_mapper.sv
// Directed self-checking bench for fsm_pin_mapper.
module tb_fsm_pin_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, restart;
  logic [4:0]  out_base, set_base, sideset_base;
  logic [5:0]  out_count;
  logic [2:0]  set_count, sideset_count;
  logic        sideset_pindir;
  logic        out_valid, out_dest, set_valid, set_dest, sideset_valid;
  logic [31:0] out_data;
  logic [4:0]  set_data, sideset_data;
  logic [31:0] pin_output, pin_drive;
  logic        collision;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fsm_pin_mapper dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .out_base(out_base), .out_count(out_count),
    .set_base(set_base), .set_count(set_count),
    .sideset_base(sideset_base), .sideset_count(sideset_count),
    .sideset_pindir(sideset_pindir),
    .out_valid(out_valid), .out_dest(out_dest), .out_data(out_data),
    .set_valid(set_valid), .set_dest(set_dest), .set_data(set_data),
    .sideset_valid(sideset_valid), .sideset_data(sideset_data),
    .pin_output(pin_output), .pin_drive(pin_drive), .collision(collision)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    restart = 0; out_valid = 0; set_valid = 0; sideset_valid = 0;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; enable = 0; idle();
    out_base = 0; out_count = 0; out_dest = 0; out_data = 0;
    set_base = 0; set_count = 0; set_dest = 0; set_data = 0;
    sideset_base = 0; sideset_count = 0; sideset_pindir = 0; sideset_data = 0;
    step(); step();
    check("rst_output", pin_output, 32'h0);
    check("rst_drive", pin_drive, 32'h0);
    check("rst_collision", {31'b0, collision}, 32'h0);
    rst_n = 1; enable = 1;

    // OUT wrap-around; no combinational path before the edge
    out_valid = 1; out_dest = 0; out_base = 30; out_count = 4; out_data = 32'hF;
    #1;
    check("out_no_comb", pin_output, 32'h0);
    step(); idle();
    check("out_wrap", pin_output, 32'hC000_0003);
    check("out_wrap_drive", pin_drive, 32'h0);

    // SET to PINDIRS
    set_valid = 1; set_dest = 1; set_base = 4; set_count = 3; set_data = 5'b00101;
    step(); idle();
    check("set_drive", pin_drive, 32'h0000_0050);
    check("set_output_hold", pin_output, 32'hC000_0003);

    // Side-set overrides OUT low bits (same result in both builds)
    out_valid = 1; out_dest = 0; out_base = 0; out_count = 8; out_data = 32'hAA;
    sideset_valid = 1; sideset_pindir = 0; sideset_base = 0; sideset_count = 2;
    sideset_data = 5'b00011;
    step(); idle();
    check("ss_override", pin_output, 32'hC000_00AB);
    check("ss_no_collision", {31'b0, collision}, 32'h0);

    // enable low ignores strobes
    enable = 0;
    out_valid = 1; out_dest = 0; out_base = 0; out_count = 32; out_data = 32'h1234_5678;
    set_valid = 1; set_dest = 1; set_count = 5; set_data = 5'h1F;
    step(); idle(); enable = 1;
    check("dis_output", pin_output, 32'hC000_00AB);
    check("dis_drive", pin_drive, 32'h0000_0050);
    check("dis_collision", {31'b0, collision}, 32'h0);

    // OUT count above 32 clamps to full width, rotated by base
    out_valid = 1; out_dest = 1; out_base = 5; out_count = 63; out_data = 32'h1234_5678;
    step(); idle();
    check("out_clamp", pin_drive, 32'h468A_CF02);

    // count 0 is a no-op
    out_valid = 1; out_dest = 0; out_base = 3; out_count = 0; out_data = 32'hFFFF_FFFF;
    step(); idle();
    check("out_cnt0", pin_output, 32'hC000_00AB);

    // OUT/SET collision: OUT wins, flag sticks
    out_valid = 1; out_dest = 0; out_base = 0; out_count = 4; out_data = 32'h5;
    set_valid = 1; set_dest = 0; set_base = 0; set_count = 4; set_data = 5'hA;
    step(); idle();
    check("coll_output", pin_output, 32'hC000_00A5);
    check("coll_flag", {31'b0, collision}, 32'h1);
    step();
    check("coll_sticky", {31'b0, collision}, 32'h1);

    // restart beats a same-cycle OUT
    restart = 1; out_valid = 1; out_dest = 0; out_base = 0; out_count = 32;
    out_data = 32'hFFFF_FFFF;
    step(); idle();
    check("rs_output", pin_output, 32'h0);
    check("rs_drive", pin_drive, 32'h0);
    check("rs_collision", {31'b0, collision}, 32'h0);

    // Seed bit 10 so the side-set window's top bit is observable
    out_valid = 1; out_dest = 0; out_base = 0; out_count = 32; out_data = 32'h0000_0400;
    step(); idle();
    check("seed", pin_output, 32'h0000_0400);

    sideset_valid = 1; sideset_pindir = 0; sideset_base = 8; sideset_count = 3;
    sideset_data = 5'b00011;
    step(); idle();
`ifdef SIDESET_OPT_EN
    check("ss_011", pin_output, 32'h0000_0400);
`else
    check("ss_011", pin_output, 32'h0000_0300);
`endif
    sideset_valid = 1; sideset_data = 5'b00111;
    step(); idle();
    check("ss_111", pin_output, 32'h0000_0700);

    // OUT PINS and side-set PINDIRS in the same cycle are independent
    out_valid = 1; out_dest = 0; out_base = 0; out_count = 4; out_data = 32'hF;
    sideset_valid = 1; sideset_pindir = 1; sideset_base = 0; sideset_count = 2;
    sideset_data = 5'b00011;
    step(); idle();
    check("indep_output", pin_output, 32'h0000_070F);
`ifdef SIDESET_OPT_EN
    check("indep_drive", pin_drive, 32'h0000_0001);
`else
    check("indep_drive", pin_drive, 32'h0000_0003);
`endif

    // Side-set count above 5 clamps to 5, wrapping at pin 31
    sideset_valid = 1; sideset_pindir = 1; sideset_base = 30; sideset_count = 7;
    sideset_data = 5'b11111;
    step(); idle();
`ifdef SIDESET_OPT_EN
    check("ss_clamp", pin_drive, 32'hC000_0003);
`else
    check("ss_clamp", pin_drive, 32'hC000_0007);
`endif

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 0;
    #1;
    check("arst_output", pin_output, 32'h0);
    check("arst_drive", pin_drive, 32'h0);
    check("arst_collision", {31'b0, collision}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_pin_mapper.md
Name: fsm_pin_mapper

Overview:
- Per-state-machine pin state unit that sits directly upstream of the output arbitrator. One instance per FSM, so 16 in total (4 cores x 4 FSMs).
- Holds that FSM's sticky 32-bit pin output and pin drive (direction) registers.
- Applies OUT, SET and side-set writes from the FSM's instruction decode, using per-FSM base/count pin mapping with wrap-around.
- Its registered outputs feed the arbitrator's fsm_output/fsm_drive slot for that core/FSM.

Parameters:
- NUM_PINS, 32, GPIO count; must be 32 (base fields are 5 bits, rotation is mod 32).
- SET_MAX, 5, maximum SET and side-set field width in bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  FSM enabled; writes are ignored when low
- restart  input  1  synchronous clear of pin state and collision flag
- out_base  input  5  first pin for OUT
- out_count  input  6  OUT width, 0..32; values above 32 clamp to 32
- set_base  input  5  first pin for SET
- set_count  input  3  SET width, 0..5; values above 5 clamp to 5
- sideset_base  input  5  first pin for side-set
- sideset_count  input  3  side-set width, 0..5; values above 5 clamp to 5
- sideset_pindir  input  1  0: side-set writes pin_output; 1: side-set writes pin_drive
- out_valid  input  1  OUT write strobe
- out_dest  input  1  0: PINS, 1: PINDIRS
- out_data  input  32  OUT data, LSB-aligned
- set_valid  input  1  SET write strobe
- set_dest  input  1  0: PINS, 1: PINDIRS
- set_data  input  5  SET data, LSB-aligned
- sideset_valid  input  1  side-set strobe
- sideset_data  input  5  side-set data, LSB-aligned
- pin_output  output  32  registered output values, to arbitrator fsm_output
- pin_drive  output  32  registered drive enables, to arbitrator fsm_drive
- collision  output  1  sticky: OUT and SET were strobed in the same cycle

Behaviour:
- Reset: rst_n low asynchronously forces pin_output=0, pin_drive=0, collision=0.
- Latency: a write strobed in cycle N is visible on the outputs after edge N+1. The outputs are pure flops with no combinational path from the inputs.
- Mapping for each write: mask = count consecutive ones starting at bit base, wrapping from pin 31 to pin 0. data_rot = data rotated left by base.
  - Target register update: reg = (reg & ~mask) | (data_rot & mask).
  - Bits outside the mask hold.
  - count==0 is a no-op.
- Per-cycle order, with later steps overriding earlier ones on overlapping pins:
  1. OUT or SET.
  2. Side-set.
- Simultaneous OUT and SET:
  - OUT is applied and SET is dropped.
  - collision is set and stays set until restart or reset.
- Side-set with valid OUT/SET to the same register and overlapping pins: side-set wins on the overlapped bits; the other bits take the OUT/SET values.
- Writes to different registers (e.g. OUT PINS plus side-set PINDIRS) apply independently in the same cycle.
- enable low: all strobes are ignored and state holds. Outputs keep driving the held values; the arbitrator decides whether they win.
- restart (enable-independent):
  - Next edge sets pin_output=0, pin_drive=0, collision=0.
  - Overrides any same-cycle writes.
- No state machine beyond the register file and the sticky flag; no backpressure, and every strobe is accepted in its cycle.

Optional Feature:
- Macro: SIDESET_OPT_EN
- Defined:
  - sideset_data[sideset_count-1] is an enable bit.
  - Enable bit 0: no side-set this cycle.
  - Enable bit 1: the low sideset_count-1 bits are applied at sideset_base.
  - sideset_count of 0 or 1 is always a no-op.
- Undefined: all sideset_count bits are applied whenever sideset_valid is high.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> pin_output=0, pin_drive=0 and collision=0 immediately, without waiting for a clock edge.
- OUT wrap-around: OUT PINS, base=30, count=4, data=0xF, with pin_output previously 0 -> pin_output=0xC0000003 one cycle later; pin_drive unchanged.
- SET to drive: SET PINDIRS, base=4, count=3, data=3'b101, with pin_drive previously 0 -> pin_drive=0x00000050.
- Side-set override: OUT PINS base=0 count=8 data=0xAA, plus side-set (pindir=0) base=0 count=2 data=2'b11, same cycle -> pin_output=0x000000AB; collision stays 0.
- OUT/SET collision, then restart:
  - OUT PINS base=0 count=4 data=0x5 with SET PINS base=0 count=4 data=0xA -> pin_output=0x5, collision=1.
  - Next, restart with out_valid=1 -> pin_output=0, pin_drive=0, collision=0.
- SIDESET_OPT_EN defined, sideset_count=3, base=8:
  - data=3'b011 -> no change.
  - data=3'b111 -> bits 8 and 9 of pin_output set.
  - Undefined build, data=3'b011 -> bits 8 and 9 set, bit 10 cleared.
